seg7_ascii_reader: RTL and testbench

Reads back the 7-segment pattern stream driven toward the display and turns it into ASCII characters. Use it for display self-check and for loopback of the message path. Each candidate pattern must be stable for a programmable number of cycles before it is accepted. A pattern is emitted only when it differs from the last one accepted. Decoded characters are queued in a small FIFO with a valid/ready output handshake.

---
 rtl/seg_reader_pkg.sv | 37 +++
 rtl/seg_reader_fifo.sv | 63 ++++++
 rtl/seg7_ascii_reader.sv | 127 ++++++++++++
 tb/tb_seg7_ascii_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_reader_pkg.sv
// Shared types, constants and the 7-segment to ASCII decode table for the segment reader.
package seg_reader_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [7:0] ascii_t;

    typedef enum logic {
        TRACK,
        LOCKED
    } filt_state_t;

    localparam seg_t   SEG_BLANK   = 7'h7F;
    localparam ascii_t ASCII_QMARK = 8'h3F;

    // Patterns are {g,f,e,d,c,b,a}, active-low; known is cleared for anything not in the table.
    function automatic ascii_t seg_to_ascii(input seg_t seg, output logic known);
        ascii_t ch;
        known = 1'b1;
        case (seg)
            7'b0001001: ch = 8'h48;
            7'b0000110: ch = 8'h45;
            7'b1000111: ch = 8'h4C;
            7'b1000000: ch = 8'h4F;
            7'b1111001: ch = 8'h31;
            7'b0100100: ch = 8'h32;
            7'b0110000: ch = 8'h33;
            7'b0011001: ch = 8'h34;
            7'b1111111: ch = 8'h20;
            default: begin
                ch    = 8'h00;
                known = 1'b0;
            end
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/seg_reader_fifo.sv
// First-word fall-through FIFO for decoded characters; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module seg_reader_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LEVEL_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = level_reg;
    // Head is presented combinationally; forced to zero while empty so the reset value is defined.
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/seg7_ascii_reader.sv
// Debounces the read-back segment stream, decodes accepted patterns to ASCII and queues them.
// Define SEG_READER_ERR_EN to emit '?' for unknown patterns and raise the sticky err flag.
module seg7_ascii_reader
    import seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               seg_in,
    input  logic                     clr,
    output logic [7:0]               out_ascii,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     err
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    filt_state_t   state_reg;
    seg_t          cand_reg;
    seg_t          last_reg;
    logic [CW-1:0] cnt_reg;
    logic          overflow_reg;

    logic   accept;
    logic   is_new;
    logic   dec_known;
    ascii_t dec_char;
    logic   push_req;
    ascii_t push_data;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   overflow_set;

    always_comb begin
        accept   = (state_reg == TRACK) && (seg_in == cand_reg) && (cnt_reg == CNT_LAST);
        is_new   = (cand_reg != last_reg);
        dec_char = seg_to_ascii(cand_reg, dec_known);
`ifdef SEG_READER_ERR_EN
        push_req  = accept && is_new;
        push_data = dec_known ? dec_char : ASCII_QMARK;
`else
        push_req  = accept && is_new && dec_known;
        push_data = dec_char;
`endif
    end

    // A change of input restarts the count from any state; LOCKED simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOCKED;
            cand_reg  <= SEG_BLANK;
            last_reg  <= SEG_BLANK;
            cnt_reg   <= '0;
        end else if (seg_in != cand_reg) begin
            cand_reg  <= seg_in;
            cnt_reg   <= CW'(1);
            state_reg <= TRACK;
        end else if (state_reg == TRACK) begin
            if (cnt_reg == CNT_LAST) begin
                state_reg <= LOCKED;
                last_reg  <= cand_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign pop          = out_valid && out_ready;
    assign overflow_set = push_req && fifo_full && !pop;

    seg_reader_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (push_data),
        .dout  (out_ascii),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    // Set has priority over clr so a coinciding event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (overflow_set) begin
            overflow_reg <= 1'b1;
        end else if (clr) begin
            overflow_reg <= 1'b0;
        end
    end
    assign overflow = overflow_reg;

`ifdef SEG_READER_ERR_EN
    logic err_reg;
    logic err_set;

    assign err_set = accept && is_new && !dec_known;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end else if (clr) begin
            err_reg <= 1'b0;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_ascii_reader.sv
// Directed bench for seg7_ascii_reader at STABLE_CYCLES=4, DEPTH=8.
module tb_seg7_ascii_reader;

    localparam logic [6:0] P_H   = 7'b0001001;
    localparam logic [6:0] P_E   = 7'b0000110;
    localparam logic [6:0] P_L   = 7'b1000111;
    localparam logic [6:0] P_O   = 7'b1000000;
    localparam logic [6:0] P_4   = 7'b0011001;
    localparam logic [6:0] P_BLK = 7'b1111111;
    localparam logic [6:0] P_UNK = 7'b0101010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       clr;
    logic [7:0] out_ascii;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;
    logic       overflow;
    logic       err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] rx[$];

    seg7_ascii_reader #(
        .STABLE_CYCLES (4),
        .DEPTH         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .clr       (clr),
        .out_ascii (out_ascii),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Records each character the consumer takes, just before the popping edge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            rx.push_back(out_ascii);
            $display("rx char 0x%02h", out_ascii);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input logic [6:0] s, input int n);
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; seg_in = P_BLK; clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(P_H, 4);
        n_cmp++; if (level !== 4'd1) begin n_mis++; $display("FAIL reset_pre_level: got %0d expected 1", level); end
        rst_n = 1'b0;
        seg_in = P_BLK;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_cmp++; if (out_ascii !== 8'h00) begin n_mis++; $display("FAIL reset_ascii: got %02h expected 00", out_ascii); end
        n_cmp++; if (overflow !== 1'b0 || err !== 1'b0) begin n_mis++; $display("FAIL reset_flags: got ovf=%b err=%b expected 0 0", overflow, err); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        hold(P_BLK, 10);
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL reset_blank_level: got %0d expected 0", level); end
        n_cmp++; if (rx.size() != 0) begin n_mis++; $display("FAIL reset_blank_rx: got %0d chars expected 0", rx.size()); end
    endtask

    task automatic test_single_accept;
        out_ready = 1'b0;
        rx.delete();
        hold(P_H, 3);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL single_early: got valid %b expected 0", out_valid); end
        hold(P_H, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_ascii !== 8'h48) begin n_mis++; $display("FAIL single_ascii: got %02h expected 48", out_ascii); end
        hold(P_H, 6);
        n_cmp++; if (level !== 4'd1) begin n_mis++; $display("FAIL single_level: got %0d expected 1", level); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL single_pop_level: got %0d expected 0", level); end
        n_cmp++; if (rx.size() != 1 || rx[0] !== 8'h48) begin n_mis++; $display("FAIL single_rx: got %0d chars first %02h expected 1 char 48", rx.size(), rx[0]); end
    endtask

    task automatic test_glitch;
        string exp_s;
        exp_s = "HEL LO";
        out_ready = 1'b1;
        hold(P_BLK, 4);
        @(negedge clk);
        rx.delete();
        hold(P_E, 3);
        hold(P_H, 4);
        hold(P_E, 4);
        hold(P_L, 4);
        hold(P_BLK, 4);
        hold(P_L, 4);
        hold(P_O, 4);
        repeat (3) @(negedge clk);
        n_cmp++; if (rx.size() != 6) begin n_mis++; $display("FAIL glitch_count: got %0d chars expected 6", rx.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rx.size() <= i || rx[i] !== exp_s[i]) begin
                n_mis++; $display("FAIL glitch_char%0d: got %02h expected %02h", i, (rx.size() > i) ? rx[i] : 8'hxx, exp_s[i]);
            end
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        rx.delete();
        for (int i = 0; i < 8; i++) begin
            hold((i % 2 == 0) ? P_H : P_E, 4);
        end
        n_cmp++; if (level !== 4'd8) begin n_mis++; $display("FAIL ovf_full_level: got %0d expected 8", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        clr = 1'b1;
        hold(P_H, 4);
        clr = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_cmp++; if (level !== 4'd8) begin n_mis++; $display("FAIL ovf_drop_level: got %0d expected 8", level); end
        hold(P_E, 3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (level !== 4'd8) begin n_mis++; $display("FAIL ovf_pushpop_level: got %0d expected 8", level); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL ovf_drain_level: got %0d expected 0", level); end
        n_cmp++; if (rx.size() != 9) begin n_mis++; $display("FAIL ovf_drain_count: got %0d chars expected 9", rx.size()); end
        n_cmp++; if (rx.size() != 9 || rx[0] !== 8'h48 || rx[7] !== 8'h45 || rx[8] !== 8'h45) begin
            n_mis++; $display("FAIL ovf_drain_order: got first %02h last %02h expected 48 45", rx[0], rx[rx.size()-1]);
        end
    endtask

    task automatic test_unknown;
        out_ready = 1'b0;
        hold(P_UNK, 3);
        n_cmp++; if (err !== 1'b0 || level !== 4'd0) begin n_mis++; $display("FAIL unk_early: got err=%b level=%0d expected 0 0", err, level); end
        hold(P_UNK, 1);
`ifdef SEG_READER_ERR_EN
        n_cmp++; if (level !== 4'd1 || out_ascii !== 8'h3F) begin n_mis++; $display("FAIL unk_push: got level=%0d ascii=%02h expected 1 3f", level, out_ascii); end
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL unk_err: got %b expected 1", err); end
`else
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL unk_push: got level=%0d expected 0", level); end
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL unk_err: got %b expected 0", err); end
`endif
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL unk_clr: got %b expected 0", err); end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        hold(P_4, 2);
        rst_n = 1'b0;
        seg_in = P_BLK;
        #1;
        n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_reset: got level=%0d valid=%b expected 0 0", level, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        hold(P_BLK, 6);
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL mid_blank: got level=%0d expected 0", level); end
        hold(P_4, 3);
        n_cmp++; if (level !== 4'd0) begin n_mis++; $display("FAIL mid_early: got level=%0d expected 0", level); end
        hold(P_4, 1);
        n_cmp++; if (level !== 4'd1 || out_ascii !== 8'h34) begin n_mis++; $display("FAIL mid_accept: got level=%0d ascii=%02h expected 1 34", level, out_ascii); end
    endtask

    initial begin
        test_reset();
        test_single_accept();
        test_glitch();
        test_overflow();
        test_unknown();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
